// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern controller: mode codes, button indices
// and the decoded press request handed to the mode state machine.
package led_pattern_pkg;

    localparam int NUM_BTNS   = 5;
    localparam int BTN_LEFT   = 0;
    localparam int BTN_OFF    = 1;
    localparam int BTN_ON     = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_BOUNCE = 4;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_ON     = 3'd1,
        MODE_LEFT   = 3'd2,
        MODE_RIGHT  = 3'd3,
        MODE_BOUNCE = 3'd4
    } mode_e;

    typedef struct packed {
        logic  vld;
        mode_e mode;
    } mode_req_t;

    function automatic mode_e btn_to_mode(input int idx);
        case (idx)
            BTN_LEFT:   return MODE_LEFT;
            BTN_ON:     return MODE_ON;
            BTN_RIGHT:  return MODE_RIGHT;
            BTN_BOUNCE: return MODE_BOUNCE;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_if.sv
// Board-facing bundle: raw active-low buttons in, LED drive and mode code out.
interface led_pattern_if
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS = 4
) ();

    logic [NUM_BTNS-1:0] buttons;
    logic [N_LEDS-1:0]   leds;
    logic [2:0]          mode;

    // master is the board/stimulus side, slave is the controller
    modport master (output buttons, input leds, input mode);
    modport slave  (input buttons, output leds, output mode);

endinterface

// File: rtl/led_pattern_ctrl_btn_debounce.sv
// One push-button channel: 2-flop synchroniser, low-level debounce counter and a
// single-cycle press pulse on the accepted high-to-low transition.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          db_low;

    // Counter saturates at CNT_LAST; the DEB_CYCLES-th consecutive low sample
    // flips the debounced state and fires the pulse exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= 2'b11;
            cnt    <= '0;
            db_low <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_n};
            press <= 1'b0;
            if (sync[1]) begin
                cnt    <= '0;
                db_low <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                if (!db_low) begin
                    db_low <= 1'b1;
                    press  <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: debounced buttons select a mode; shifting modes advance
// the lit LED once every TICK_CYCLES clocks.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS      = 4,
    parameter int TICK_CYCLES = 50000000,
    parameter int DEB_CYCLES  = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    led_pattern_if.slave  bus
);

    localparam int SW = $clog2(TICK_CYCLES);
    localparam logic [SW-1:0]     STEP_LAST = SW'(TICK_CYCLES - 1);
    localparam logic [N_LEDS-1:0] LED_LSB   = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LED_MSB   = LED_LSB << (N_LEDS - 1);

    logic [NUM_BTNS-1:0] press;
    mode_req_t           req;

    mode_e             mode_q, mode_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic [SW-1:0]     step_q, step_d;
    logic              dir_up_q, dir_up_d;
    logic              step_tick;

    genvar g;
    generate
        for (g = 0; g < NUM_BTNS; g++) begin : g_btn
            btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (clk),
                .rst   (rst),
                .btn_n (bus.buttons[g]),
                .press (press[g])
            );
        end
    endgenerate

    // Scan high to low so the lowest simultaneous press is the one kept.
    always_comb begin
        req = '{vld: 1'b0, mode: MODE_OFF};
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (press[i]) begin
                req.vld  = 1'b1;
                req.mode = btn_to_mode(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            leds_q   <= '0;
            step_q   <= '0;
            dir_up_q <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            leds_q   <= leds_d;
            step_q   <= step_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign step_tick = (step_q == STEP_LAST);

    always_comb begin
        mode_d   = mode_q;
        leds_d   = leds_q;
        step_d   = '0;
        dir_up_d = dir_up_q;
        if (req.vld) begin
            // Any press, including the active mode, reloads the entry pattern.
            mode_d   = req.mode;
            dir_up_d = 1'b1;
            case (req.mode)
                MODE_ON:     leds_d = '1;
                MODE_LEFT:   leds_d = LED_LSB;
                MODE_RIGHT:  leds_d = LED_MSB;
                MODE_BOUNCE: leds_d = LED_LSB;
                default:     leds_d = '0;
            endcase
        end else begin
            case (mode_q)
                MODE_OFF: leds_d = '0;
                MODE_ON:  leds_d = '1;
                MODE_LEFT: begin
                    step_d = step_tick ? '0 : step_q + 1'b1;
                    if (step_tick)
                        leds_d = (leds_q << 1) | (leds_q >> (N_LEDS - 1));
                end
                MODE_RIGHT: begin
                    step_d = step_tick ? '0 : step_q + 1'b1;
                    if (step_tick)
                        leds_d = (leds_q >> 1) | (leds_q << (N_LEDS - 1));
                end
                MODE_BOUNCE: begin
                    step_d = step_tick ? '0 : step_q + 1'b1;
                    // Direction flips on arrival at an end, so each end bit
                    // is shown for a single step.
                    if (step_tick && N_LEDS > 1) begin
                        if (dir_up_q) begin
                            leds_d = leds_q << 1;
                            if (leds_d[N_LEDS-1]) dir_up_d = 1'b0;
                        end else begin
                            leds_d = leds_q >> 1;
                            if (leds_d[0]) dir_up_d = 1'b1;
                        end
                    end
                end
                default: begin
                    mode_d = MODE_OFF;
                    leds_d = '0;
                end
            endcase
        end
    end

    assign bus.leds = leds_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios then random button traffic,
// checked every cycle against a run-length / elapsed-time model (N_LEDS=4 and 1).
module tb_led_pattern_ctrl;
    import led_pattern_pkg::*;

    localparam int TICK = 4;
    localparam int DEB  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    led_pattern_if #(.N_LEDS(4)) bus4 ();
    led_pattern_if #(.N_LEDS(1)) bus1 ();

    assign bus4.buttons = btn;
    assign bus1.buttons = btn;

    led_pattern_ctrl #(.N_LEDS(4), .TICK_CYCLES(TICK), .DEB_CYCLES(DEB)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );
    led_pattern_ctrl #(.N_LEDS(1), .TICK_CYCLES(TICK), .DEB_CYCLES(DEB)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    // Reference model state
    int         m_mode;
    int         k;
    int         pend;
    int         run [5];
    logic [4:0] s1, s2;

    function automatic int btn2mode(input int b);
        case (b)
            0: return 2;
            2: return 1;
            3: return 3;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_leds(input int mode, input int cyc, input int n);
        int steps, p, pos;
        steps = cyc / TICK;
        case (mode)
            1: return (32'd1 << n) - 32'd1;
            2: return 32'd1 << (steps % n);
            3: return 32'd1 << (n - 1 - (steps % n));
            4: begin
                if (n == 1) return 32'd1;
                p   = steps % (2 * n - 2);
                pos = (p < n) ? p : (2 * n - 2 - p);
                return 32'd1 << pos;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        int np;
        if (rst) begin
            m_mode = 0; k = 0; pend = -1; s1 = '1; s2 = '1;
            for (int b = 0; b < 5; b++) run[b] = 0;
        end else begin
            if (pend >= 0) begin
                m_mode = btn2mode(pend);
                k = 0;
            end else begin
                k++;
            end
            np = -1;
            for (int b = 4; b >= 0; b--) begin
                if (!s2[b]) begin
                    run[b]++;
                    if (run[b] == DEB) np = b;
                end else begin
                    run[b] = 0;
                end
            end
            pend = np;
            s2 = s1;
            s1 = btn;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("mode_n4", 32'(bus4.mode), m_mode);
        check("leds_n4", 32'(bus4.leds), exp_leds(m_mode, k, 4));
        check("mode_n1", 32'(bus1.mode), m_mode);
        check("leds_n1", 32'(bus1.leds), exp_leds(m_mode, k, 1));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b0;
        ticks(hold);
        btn[b] = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        btn = '1;
        ticks(3);
        check("reset_leds", 32'(bus4.leds), 32'h0);
        check("reset_mode", 32'(bus4.mode), 32'h0);
        rst = 1'b0;
        ticks(3);

        // Short glitch on all-off is filtered out
        press(1, 2);
        ticks(8);
        check("glitch_mode", 32'(bus4.mode), 32'h0);

        // Left: 2 sync + 3 debounce + 1 cycles to first pattern
        btn[0] = 1'b0;
        ticks(5);
        check("left_not_yet", 32'(bus4.leds), 32'h0);
        tick();
        check("left_entry_leds", 32'(bus4.leds), 32'h1);
        check("left_entry_mode", 32'(bus4.mode), 32'h2);
        ticks(4);
        check("left_step1", 32'(bus4.leds), 32'h2);
        ticks(4);
        check("left_step2", 32'(bus4.leds), 32'h4);
        ticks(8);
        check("left_wrap", 32'(bus4.leds), 32'h1);
        btn[0] = 1'b1;
        ticks(6);

        // Right, then all-on mid-step
        press(3, 8);
        ticks(17);
        press(2, 8);
        ticks(10);
        check("on_hold", 32'(bus4.leds), 32'hf);

        // Bounce across both ends
        press(4, 8);
        ticks(40);

        // Simultaneous left/right: left wins; then re-enter left
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        ticks(8);
        btn = '1;
        check("prio_mode", 32'(bus4.mode), 32'h2);
        ticks(5);
        press(0, 8);
        ticks(12);

        // Reset mid-bounce takes effect on the next edge
        press(4, 8);
        ticks(7);
        rst = 1'b1;
        tick();
        check("rst_mid_leds", 32'(bus4.leds), 32'h0);
        check("rst_mid_mode", 32'(bus4.mode), 32'h0);
        rst = 1'b0;
        ticks(2);

        // Button held low through reset release needs a full debounce
        btn[2] = 1'b0;
        ticks(4);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(10);
        btn = '1;
        ticks(4);

        // Random traffic
        repeat (150) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                ticks(int'($urandom_range(1, 2)));
                rst = 1'b0;
            end
            btn = ~(5'b1 << $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) btn[$urandom_range(0, 4)] = 1'b0;
            ticks(int'($urandom_range(1, 9)));
            btn = '1;
            ticks(int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
